// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-back bypass and per-register busy scoreboard.
// Reads are registered (latency 1); busyVec is the live scoreboard state.
module regfile_mp #(
    parameter int D_WIDTH   = 32,
    parameter int NUM_REGS  = 32,
    parameter int A_WIDTH   = 5,
    parameter int NUM_RD    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        regLd,
    input  logic [NUM_RD*A_WIDTH-1:0]   rs,
    input  logic                        regStr,
    input  logic [A_WIDTH-1:0]          rd,
    input  logic [D_WIDTH-1:0]          WBDat,
    input  logic                        rsvEn,
    input  logic [A_WIDTH-1:0]          rsvAddr,
    output logic [NUM_RD*D_WIDTH-1:0]   rsOut,
    output logic [NUM_RD-1:0]           rsBusy,
    output logic                        outputValid,
    output logic [NUM_REGS-1:0]         busyVec
);

    logic [D_WIDTH-1:0]        regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]       busy_q;
    logic [NUM_REGS-1:0]       busy_nxt;
    logic                      wr_ok;
    logic                      rsv_ok;
    logic [NUM_RD*D_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]         rd_busy;

    // An address is usable if it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [A_WIDTH-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG0 != 0) && (a == '0));
    endfunction

    // Reservation is applied after the clear so a same-edge set wins.
    always_comb begin
        wr_ok    = regStr && addr_ok(rd);
        rsv_ok   = rsvEn && addr_ok(rsvAddr);
        busy_nxt = busy_q;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (wr_ok && (int'(rd) == n))
                busy_nxt[n] = 1'b0;
            if (rsv_ok && (int'(rsvAddr) == n))
                busy_nxt[n] = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (int'(rs[k*A_WIDTH +: A_WIDTH]) == n) begin
                    rd_data[k*D_WIDTH +: D_WIDTH] = regs_q[n];
                    rd_busy[k]                    = busy_nxt[n];
                end
            end
            if (!addr_ok(rs[k*A_WIDTH +: A_WIDTH])) begin
                rd_data[k*D_WIDTH +: D_WIDTH] = '0;
                rd_busy[k]                    = 1'b0;
            end else if ((BYPASS != 0) && wr_ok && (rd == rs[k*A_WIDTH +: A_WIDTH])) begin
                rd_data[k*D_WIDTH +: D_WIDTH] = WBDat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_REGS; n++)
                regs_q[n] <= '0;
            busy_q      <= '0;
            rsOut       <= '0;
            rsBusy      <= '0;
            outputValid <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (wr_ok && (int'(rd) == n))
                    regs_q[n] <= WBDat;
            end
            busy_q      <= busy_nxt;
            outputValid <= regLd;
            if (regLd) begin
                rsOut  <= rd_data;
                rsBusy <= rd_busy;
            end
        end
    end

    assign busyVec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and non-bypass instances plus a 16x64, 3-port instance.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        reg_ld, reg_str, rsv_en;
    logic [9:0]  rs;
    logic [4:0]  rd, rsv_addr;
    logic [31:0] wb_dat;
    logic [63:0] rs_out, rs_out_nb;
    logic [1:0]  rs_busy, rs_busy_nb;
    logic        ov, ov_nb;
    logic [31:0] busy_vec, busy_vec_nb;

    logic         p_reg_ld, p_reg_str, p_rsv_en;
    logic [14:0]  p_rs;
    logic [4:0]   p_rd, p_rsv_addr;
    logic [63:0]  p_wb;
    logic [191:0] p_rs_out;
    logic [2:0]   p_rs_busy;
    logic         p_ov;
    logic [15:0]  p_busy_vec;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .regLd(reg_ld), .rs(rs), .regStr(reg_str), .rd(rd),
        .WBDat(wb_dat), .rsvEn(rsv_en), .rsvAddr(rsv_addr), .rsOut(rs_out),
        .rsBusy(rs_busy), .outputValid(ov), .busyVec(busy_vec)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .regLd(reg_ld), .rs(rs), .regStr(reg_str), .rd(rd),
        .WBDat(wb_dat), .rsvEn(rsv_en), .rsvAddr(rsv_addr), .rsOut(rs_out_nb),
        .rsBusy(rs_busy_nb), .outputValid(ov_nb), .busyVec(busy_vec_nb)
    );

    regfile_mp #(.D_WIDTH(64), .NUM_REGS(16), .A_WIDTH(5), .NUM_RD(3)) dut_p (
        .clk(clk), .rst_n(rst_n), .regLd(p_reg_ld), .rs(p_rs), .regStr(p_reg_str), .rd(p_rd),
        .WBDat(p_wb), .rsvEn(p_rsv_en), .rsvAddr(p_rsv_addr), .rsOut(p_rs_out),
        .rsBusy(p_rs_busy), .outputValid(p_ov), .busyVec(p_busy_vec)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        tag;
        bit           is_p;
        logic [191:0] exp_out;
        logic [2:0]   exp_busy;
        logic [63:0]  exp_out_nb;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input bit is_p, input logic [191:0] eo,
                        input logic [2:0] eb, input logic [63:0] eo_nb);
        exp_t e;
        e.tag = tag; e.is_p = is_p; e.exp_out = eo; e.exp_busy = eb; e.exp_out_nb = eo_nb;
        sb.push_back(e);
    endtask

    // One clock: sample just after the edge, retire the pending read, then drop strobes.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.is_p) begin
                check({e.tag, "/out"},     192'(rs_out),     e.exp_out);
                check({e.tag, "/busy"},    192'(rs_busy),    192'(e.exp_busy));
                check({e.tag, "/valid"},   192'(ov),         192'(1));
                check({e.tag, "/nb_out"},  192'(rs_out_nb),  192'(e.exp_out_nb));
                check({e.tag, "/nb_busy"}, 192'(rs_busy_nb), 192'(e.exp_busy));
            end else begin
                check({e.tag, "/out"},   p_rs_out,         e.exp_out);
                check({e.tag, "/busy"},  192'(p_rs_busy),  192'(e.exp_busy));
                check({e.tag, "/valid"}, 192'(p_ov),       192'(1));
            end
        end
        reg_ld = 0; reg_str = 0; rsv_en = 0;
        p_reg_ld = 0; p_reg_str = 0; p_rsv_en = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pat;
        pat = 64'h0123_4567_89AB_CDEF;
        rst_n = 0;
        reg_ld = 0; reg_str = 0; rsv_en = 0; rs = '0; rd = '0; rsv_addr = '0; wb_dat = '0;
        p_reg_ld = 0; p_reg_str = 0; p_rsv_en = 0; p_rs = '0; p_rd = '0; p_rsv_addr = '0; p_wb = '0;

        // Reset held with random strobes
        for (int i = 0; i < 10; i++) begin
            reg_ld = 1'($urandom); reg_str = 1'($urandom); rsv_en = 1'($urandom);
            rs = 10'($urandom); rd = 5'($urandom); rsv_addr = 5'($urandom); wb_dat = $urandom;
            tick();
        end
        check("rst/out",      192'(rs_out),     192'(0));
        check("rst/busy",     192'(rs_busy),    192'(0));
        check("rst/valid",    192'(ov),         192'(0));
        check("rst/busyvec",  192'(busy_vec),   192'(0));
        check("rst/p_out",    p_rs_out,         192'(0));
        check("rst/p_valid",  192'(p_ov),       192'(0));
        rst_n = 1;

        // Write then read
        reg_str = 1; rd = 5'd5; wb_dat = 32'hDEADBEEF; tick();
        reg_str = 1; rd = 5'd9; wb_dat = 32'h12345678; tick();
        reg_ld = 1; rs = {5'd9, 5'd5};
        push("wr_rd", 0, 192'({32'h12345678, 32'hDEADBEEF}), 3'b000, {32'h12345678, 32'hDEADBEEF});
        tick();
        tick();
        check("hold/valid", 192'(ov),     192'(0));
        check("hold/out",   192'(rs_out), 192'({32'h12345678, 32'hDEADBEEF}));

        // Register 0 is hardwired
        reg_str = 1; rd = 5'd0; wb_dat = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 5'd0; tick();
        check("r0/busyvec", 192'(busy_vec), 192'(0));
        reg_ld = 1; rs = {5'd0, 5'd0};
        push("r0_rd", 0, 192'(0), 3'b000, 64'h0);
        tick();

        // Bypass versus pre-write value
        reg_str = 1; rd = 5'd7; wb_dat = 32'h11111111; tick();
        reg_str = 1; rd = 5'd7; wb_dat = 32'hA5A5A5A5; reg_ld = 1; rs = {5'd7, 5'd7};
        push("bypass", 0, 192'({32'hA5A5A5A5, 32'hA5A5A5A5}), 3'b000, {32'h11111111, 32'h11111111});
        tick();
        reg_ld = 1; rs = {5'd7, 5'd7};
        push("after_byp", 0, 192'({32'hA5A5A5A5, 32'hA5A5A5A5}), 3'b000, {32'hA5A5A5A5, 32'hA5A5A5A5});
        tick();

        // Scoreboard
        rsv_en = 1; rsv_addr = 5'd3; tick();
        check("rsv3/busyvec", 192'(busy_vec), 192'(32'h8));
        reg_ld = 1; rs = {5'd0, 5'd3};
        push("rsv3_rd", 0, 192'(0), 3'b001, 64'h0);
        tick();
        reg_str = 1; rd = 5'd3; wb_dat = 32'hCAFEF00D; tick();
        check("clr3/busyvec", 192'(busy_vec), 192'(0));
        reg_str = 1; rd = 5'd3; wb_dat = 32'h0BADC0DE; rsv_en = 1; rsv_addr = 5'd3; tick();
        check("setwins/busyvec", 192'(busy_vec), 192'(32'h8));
        reg_ld = 1; rs = {5'd3, 5'd3};
        push("setwins_rd", 0, 192'({32'h0BADC0DE, 32'h0BADC0DE}), 3'b011, {32'h0BADC0DE, 32'h0BADC0DE});
        tick();
        reg_str = 1; rd = 5'd3; wb_dat = 32'h77777777; reg_ld = 1; rs = {5'd3, 5'd3};
        push("clr_rd", 0, 192'({32'h77777777, 32'h77777777}), 3'b000, {32'h0BADC0DE, 32'h0BADC0DE});
        tick();
        check("clr_rd/busyvec", 192'(busy_vec), 192'(0));

        // Reserve during read, then asynchronous reset mid-operation
        reg_ld = 1; rs = {5'd9, 5'd5}; rsv_en = 1; rsv_addr = 5'd9;
        push("rsv_rd", 0, 192'({32'h12345678, 32'hDEADBEEF}), 3'b010, {32'h12345678, 32'hDEADBEEF});
        tick();
        check("pre_arst/busyvec", 192'(busy_vec), 192'(32'h200));
        #2 rst_n = 0;
        #1;
        check("arst/out",     192'(rs_out),   192'(0));
        check("arst/busy",    192'(rs_busy),  192'(0));
        check("arst/valid",   192'(ov),       192'(0));
        check("arst/busyvec", 192'(busy_vec), 192'(0));
        @(posedge clk); #1 rst_n = 1;
        reg_ld = 1; rs = {5'd9, 5'd5};
        push("post_arst", 0, 192'(0), 3'b000, 64'h0);
        tick();

        // 16 x 64-bit, 3-port instance
        p_reg_str = 1; p_rd = 5'd15; p_wb = pat; tick();
        p_reg_ld = 1; p_rs = {5'd15, 5'd15, 5'd15};
        push("p_r15", 1, {pat, pat, pat}, 3'b000, 64'h0);
        tick();
        p_rsv_en = 1; p_rsv_addr = 5'd2; tick();
        check("p_rsv2/busyvec", 192'(p_busy_vec), 192'(16'h0004));
        p_reg_str = 1; p_rd = 5'd20; p_wb = 64'hFFFF_FFFF_FFFF_FFFF; p_rsv_en = 1; p_rsv_addr = 5'd20; tick();
        check("p_r20/busyvec", 192'(p_busy_vec), 192'(16'h0004));
        p_reg_ld = 1; p_rs = {5'd4, 5'd15, 5'd20};
        push("p_r20_rd", 1, {64'h0, pat, 64'h0}, 3'b000, 64'h0);
        tick();
        p_reg_ld = 1; p_rs = {5'd2, 5'd2, 5'd2};
        push("p_r2_busy", 1, 192'(0), 3'b111, 64'h0);
        tick();

        check("sb/drained", 192'(sb.size()), 192'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
